// File: rtl/pps_pkg.sv
// Shared definitions for the PPS blocks (pps_gen, pps_phase_meas).
//   pps_state_e     : measurement FSM states
//   CLK_HZ          : system clock rate
//   DEFAULT_TIMEOUT : default edge-pairing window, one second of clocks
//   sat_inc8        : 8-bit saturating increment
package pps_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DUT,
    ST_WAIT_REF,
    ST_HOLD
  } pps_state_e;

  localparam int unsigned CLK_HZ          = 100000000;
  localparam int unsigned DEFAULT_TIMEOUT = CLK_HZ;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pps_edge_det.sv
// Three-flop synchronizer with rising-edge pulse.
//   i_clk   : system clock
//   i_res   : synchronous active-high reset, clears the chain
//   i_in    : asynchronous level input
//   o_pulse : one-cycle pulse when the synchronized level goes 0 -> 1
module pps_edge_det (
  input  logic i_clk,
  input  logic i_res,
  input  logic i_in,
  output logic o_pulse
);

  logic [2:0] ff_q;
  logic [2:0] ff_d;

  always_comb begin
    ff_d = {ff_q[1:0], i_in};
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      ff_q <= '0;
    end else begin
      ff_q <= ff_d;
    end
  end

  assign o_pulse = (ff_q[2:1] == 2'b01);

endmodule

// File: rtl/pps_phase_meas.sv
// Signed phase measurement between reference PPS and locally generated PPS.
//   i_clk, i_res      : 100 MHz clock, synchronous active-high reset
//   i_pps_ref         : reference PPS (asynchronous)
//   i_pps_dut         : generated PPS
//   o_valid / i_ready : result handshake
//   o_phase           : signed t_dut - t_ref in clocks (positive: DUT lags)
//   o_timeout         : result is a timeout rather than a measurement
//   o_busy            : a measurement window is open
//   o_drop_cnt        : saturating count of edges ignored while a result is
//                       held; present only when PPS_PHASE_MEAS_DROP_CNT_EN
//                       is defined
module pps_phase_meas
  import pps_pkg::*;
#(
  parameter int unsigned CNT_W   = 28,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_res,
  input  logic             i_pps_ref,
  input  logic             i_pps_dut,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CNT_W-1:0] o_phase,
  output logic             o_timeout,
  output logic             o_busy
`ifdef PPS_PHASE_MEAS_DROP_CNT_EN
  ,
  output logic [7:0]       o_drop_cnt
`endif
);

  localparam logic [CNT_W-2:0] TIMEOUT_CNT = (CNT_W-1)'(TIMEOUT);
  localparam logic [CNT_W-2:0] CNT_ONE     = (CNT_W-1)'(1);
  localparam logic [CNT_W-1:0] PHASE_TO_POS = {1'b0, TIMEOUT_CNT};
  localparam logic [CNT_W-1:0] PHASE_TO_NEG = -PHASE_TO_POS;

  logic ref_pulse;
  logic dut_pulse;

  pps_edge_det u_edge_ref (
    .i_clk   (i_clk),
    .i_res   (i_res),
    .i_in    (i_pps_ref),
    .o_pulse (ref_pulse)
  );

  pps_edge_det u_edge_dut (
    .i_clk   (i_clk),
    .i_res   (i_res),
    .i_in    (i_pps_dut),
    .o_pulse (dut_pulse)
  );

  pps_state_e       state_q, state_d;
  logic [CNT_W-2:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    timeout_d = timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ref_pulse && dut_pulse) begin
          state_d   = ST_HOLD;
          phase_d   = '0;
          timeout_d = 1'b0;
        end else if (ref_pulse) begin
          state_d = ST_WAIT_DUT;
          cnt_d   = CNT_ONE;
        end else if (dut_pulse) begin
          state_d = ST_WAIT_REF;
          cnt_d   = CNT_ONE;
        end
      end

      // Partner edge takes priority over both restart and timeout, so an
      // edge landing exactly at cnt == TIMEOUT is still a measurement.
      ST_WAIT_DUT: begin
        if (dut_pulse) begin
          state_d   = ST_HOLD;
          phase_d   = {1'b0, cnt_q};
          timeout_d = 1'b0;
        end else if (ref_pulse) begin
          cnt_d = CNT_ONE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d   = ST_HOLD;
          phase_d   = PHASE_TO_POS;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_WAIT_REF: begin
        if (ref_pulse) begin
          state_d   = ST_HOLD;
          phase_d   = -{1'b0, cnt_q};
          timeout_d = 1'b0;
        end else if (dut_pulse) begin
          cnt_d = CNT_ONE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d   = ST_HOLD;
          phase_d   = PHASE_TO_NEG;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_HOLD: begin
        if (i_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      phase_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_valid   = (state_q == ST_HOLD);
  assign o_phase   = phase_q;
  assign o_timeout = timeout_q;
  assign o_busy    = (state_q == ST_WAIT_DUT) || (state_q == ST_WAIT_REF);

`ifdef PPS_PHASE_MEAS_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  // Two increments so a simultaneous pair in HOLD counts as two drops.
  always_comb begin
    drop_d = drop_q;
    if (state_q == ST_HOLD) begin
      if (ref_pulse) drop_d = sat_inc8(drop_d);
      if (dut_pulse) drop_d = sat_inc8(drop_d);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign o_drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_pps_phase_meas.sv
module tb_pps_phase_meas;

  localparam int unsigned CNT_W = 28;
  localparam int unsigned TO    = 1000;

  logic             clk = 1'b0;
  logic             i_res;
  logic             i_pps_ref;
  logic             i_pps_dut;
  logic             i_ready;
  logic             o_valid;
  logic [CNT_W-1:0] o_phase;
  logic             o_timeout;
  logic             o_busy;
`ifdef PPS_PHASE_MEAS_DROP_CNT_EN
  logic [7:0]       o_drop_cnt;
`endif

  pps_phase_meas #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TO)
  ) dut (
    .i_clk      (clk),
    .i_res      (i_res),
    .i_pps_ref  (i_pps_ref),
    .i_pps_dut  (i_pps_dut),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_phase    (o_phase),
    .o_timeout  (o_timeout),
    .o_busy     (o_busy)
`ifdef PPS_PHASE_MEAS_DROP_CNT_EN
    ,
    .o_drop_cnt (o_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int ref_off;      // cycle the ref input rises, -1 = never
    int dut_off;      // cycle the dut input rises, -1 = never
    int ready_delay;  // cycles i_ready stays low once o_valid is seen
    int exp_phase;
    bit exp_to;
  } vec_t;

  typedef struct {
    int phase;
    bit to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int phase_int();
    return int'($signed(o_phase));
  endfunction

  // Scoreboard: pop one expected result per handshake transfer.
  always @(negedge clk) begin
    if (!i_res && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got phase %0d expected no result", phase_int());
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_phase", phase_int(), e.phase);
        check("sb_timeout", int'(o_timeout), int'(e.to));
      end
    end
  end

  // Returns number of ticks taken (1 = valid after first tick), 0 if never.
  task automatic wait_valid(input int start, output int lat);
    int n;
    n = start;
    while (!o_valid && n < int'(TO) + 50) begin
      tick();
      n++;
    end
    if (o_valid) begin
      lat = n;
    end else begin
      lat = 0;
      check("wait_valid_bound", 0, 1);
    end
  endtask

  task automatic settle();
    i_pps_ref = 1'b0;
    i_pps_dut = 1'b0;
    repeat (6) tick();
    check("idle_valid", int'(o_valid), 0);
    check("idle_busy", int'(o_busy), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int last;
    int lat;
    exp_t e;
    i_ready = (v.ready_delay == 0);
    e.phase = v.exp_phase;
    e.to    = v.exp_to;
    sb.push_back(e);
    last = (v.ref_off > v.dut_off) ? v.ref_off : v.dut_off;
    for (int c = 0; c <= last; c++) begin
      if (c == v.ref_off) i_pps_ref = 1'b1;
      if (c == v.dut_off) i_pps_dut = 1'b1;
      tick();
    end
    wait_valid(1, lat);
    // Second input rise -> 2 sync clocks to pulse -> 1 registered clock.
    if (v.ref_off >= 0 && v.dut_off >= 0) check("valid_latency", lat, 3);
    if (v.ready_delay > 0) begin
      for (int k = 0; k < v.ready_delay; k++) begin
        check("hold_valid", int'(o_valid), 1);
        check("hold_phase", phase_int(), v.exp_phase);
        tick();
      end
      i_ready = 1'b1;
    end
    tick();
    check("valid_drop", int'(o_valid), 0);
    settle();
  endtask

  vec_t vecs[9];

  initial begin
    vec_t v;
    int   lat;
    exp_t e;

    vecs[0] = '{0,    250, 0,     250, 1'b0};
    vecs[1] = '{1000, 0,   5,   -1000, 1'b0};
    vecs[2] = '{0,    0,   0,       0, 1'b0};
    vecs[3] = '{0,    1,   0,       1, 1'b0};
    vecs[4] = '{1,    0,   2,      -1, 1'b0};
    vecs[5] = '{0,   -1,   0,    1000, 1'b1};
    vecs[6] = '{-1,   0,   3,   -1000, 1'b1};
    vecs[7] = '{0,  1000,  0,    1000, 1'b0};
    vecs[8] = '{0,   999,  0,     999, 1'b0};

    i_res     = 1'b1;
    i_pps_ref = 1'b0;
    i_pps_dut = 1'b0;
    i_ready   = 1'b1;
    repeat (3) tick();
    check("rst_valid", int'(o_valid), 0);
    check("rst_phase", phase_int(), 0);
    check("rst_timeout", int'(o_timeout), 0);
    check("rst_busy", int'(o_busy), 0);
`ifdef PPS_PHASE_MEAS_DROP_CNT_EN
    check("rst_drop", int'(o_drop_cnt), 0);
`endif
    i_res = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Window open while waiting for the partner edge.
    i_pps_ref = 1'b1;
    repeat (5) tick();
    check("busy_open", int'(o_busy), 1);
    repeat (5) tick();
    i_pps_dut = 1'b1;
    i_ready   = 1'b0;
    e.phase = 10;
    e.to    = 1'b0;
    sb.push_back(e);
    wait_valid(0, lat);
    check("busy_hold", int'(o_busy), 0);
    // Edges while holding: 3 ref and 2 dut, none produce results.
    i_pps_ref = 1'b0;
    i_pps_dut = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      i_pps_ref = 1'b1;
      repeat (4) tick();
      i_pps_ref = 1'b0;
      repeat (4) tick();
    end
    for (int i = 0; i < 2; i++) begin
      i_pps_dut = 1'b1;
      repeat (4) tick();
      i_pps_dut = 1'b0;
      repeat (4) tick();
    end
    repeat (4) tick();
    check("drop_valid", int'(o_valid), 1);
    check("drop_phase", phase_int(), 10);
`ifdef PPS_PHASE_MEAS_DROP_CNT_EN
    check("drop_cnt", int'(o_drop_cnt), 5);
`endif
    i_ready = 1'b1;
    tick();
    check("drop_release", int'(o_valid), 0);
    settle();

    // Reset mid-window discards the pending measurement.
    i_pps_ref = 1'b1;
    wait_busy_loop: for (int n = 0; n < 10 && !o_busy; n++) tick();
    check("pre_rst_busy", int'(o_busy), 1);
    repeat (399) tick();
    i_res     = 1'b1;
    i_pps_ref = 1'b0;
    tick();
    i_res = 1'b0;
    check("mid_rst_valid", int'(o_valid), 0);
    check("mid_rst_phase", phase_int(), 0);
    check("mid_rst_timeout", int'(o_timeout), 0);
    check("mid_rst_busy", int'(o_busy), 0);
`ifdef PPS_PHASE_MEAS_DROP_CNT_EN
    check("mid_rst_drop", int'(o_drop_cnt), 0);
`endif
    repeat (5) tick();
    check("post_rst_idle", int'(o_busy), 0);
    v = '{0, 30, 0, 30, 1'b0};
    run_vec(v);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/pps_phase_meas.md
# pps_phase_meas

Measures the signed phase offset, in 100 MHz clock counts, between the reference PPS (GNSS receiver) and the locally generated PPS from `pps_gen`. It sits directly downstream of `pps_gen`. Each matched pair of rising edges produces one result word, delivered over a valid/ready handshake to the host readout logic. Edges are missing when no partner edge arrives within a timeout window; the block reports these as timeouts.

## Interface
- `CNT_W`, 28: result width; the signed two's-complement magnitude counter.
- `TIMEOUT`, 100000000: maximum edge separation in clocks (1 s); must be < 2^(CNT_W-1).
- `i_clk` in 1: 100 MHz system clock.
- `i_res` in 1: reset, synchronous, active-high.
- `i_pps_ref` in 1: reference PPS, asynchronous.
- `i_pps_dut` in 1: generated PPS (`pps_gen` `o_pps`).
- `o_valid` out 1: result available.
- `i_ready` in 1: consumer accepts the result.
- `o_phase` out CNT_W: signed t_dut − t_ref in clocks; positive means DUT lags.
- `o_timeout` out 1: result is a timeout, not a measurement.
- `o_busy` out 1: a measurement window is open.
- `o_drop_cnt` out 8: present only with the macro; see Configuration.

## Operation
- Both inputs pass through identical 3-flop chains; edge pulse = `ff[2:1]==2'b01`. The latency is equal on both inputs, so it cancels.
- States:
  - IDLE:
    - ref edge only → WAIT_DUT, cnt←1.
    - dut edge only → WAIT_REF, cnt←1.
    - both edges in the same cycle → HOLD with phase 0, timeout 0.
  - WAIT_DUT: cnt←cnt+1 each cycle.
    - dut edge → HOLD, phase = +cnt.
    - repeated ref edge → restart, cnt←1.
    - cnt==TIMEOUT with no dut edge → HOLD, timeout=1.
    - A dut edge in the same cycle as cnt==TIMEOUT counts as a measurement.
  - WAIT_REF: mirror of WAIT_DUT; phase = −cnt.
  - HOLD: `o_valid`=1; `o_phase` and `o_timeout` are stable until `o_valid & i_ready`; then → IDLE.
    - All edges in HOLD are ignored, including the edge in the transfer cycle.
- Timeout result: `o_phase` = +TIMEOUT in WAIT_DUT, −TIMEOUT in WAIT_REF; `o_timeout`=1.
- The cnt width is CNT_W−1 unsigned. It never wraps, because TIMEOUT terminates counting first.
- `o_busy` = state is WAIT_DUT or WAIT_REF.

## Timing
- Reset: all synchronizer flops 0, state IDLE, cnt 0, `o_valid` 0, `o_phase` 0, `o_timeout` 0, `o_busy` 0, `o_drop_cnt` 0.
- Reset asserted mid-window or mid-HOLD discards the pending result; no partial result is output.
- An input held high through reset release is seen as one edge. Its pulse occurs on the 3rd clock after release.
- Input rise to edge pulse: 2–3 clocks.
- Second edge pulse to `o_valid`=1: 1 clock, registered.
- Edge-pulse separation k (1 ≤ k ≤ TIMEOUT) gives |`o_phase`| = k.
- Minimum IDLE re-arm: 1 clock after the transfer cycle.

## Configuration
- `PPS_PHASE_MEAS_DROP_CNT_EN` defined:
  - `o_drop_cnt` port exists. It is an 8-bit saturating count (stops at 255) of edge pulses ignored in HOLD.
  - Both inputs are counted; a simultaneous pair counts 2.
  - It is cleared only by reset.
- Not defined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package `pps_pkg`: state encoding (IDLE, WAIT_DUT, WAIT_REF, HOLD), `CLK_HZ`=100000000, and the default TIMEOUT constant. `pps_gen` should also use these.
- Sub-module `pps_edge_det`: 3-flop synchronizer plus rising-edge pulse, synchronous active-high reset. Instantiate it twice.

## Test plan
- ref rises, dut rises 250 clocks later → `o_phase`=+250, `o_timeout`=0; `o_valid` asserts 1 clock after the dut edge pulse.
- dut rises, ref rises 1000 clocks later, `i_ready` low for 5 cycles → `o_phase`=−1000, held stable for 5 cycles; `o_valid` drops the cycle after transfer.
- Both inputs rise in the same clock → `o_phase`=0, `o_timeout`=0.
- TIMEOUT=1000; only ref toggles → after 1000 counts `o_timeout`=1, `o_phase`=+1000. A dut edge at exactly count 1000 instead → `o_phase`=+1000, `o_timeout`=0.
- Result held with `i_ready`=0 while 3 ref and 2 dut edges arrive → no new results; with the macro, `o_drop_cnt`=5.
- `i_res` pulsed 1 cycle while in WAIT_DUT at cnt 400 → next cycle all outputs 0 and state IDLE. The next pair measures correctly.
